// File: rtl/cpu_hs_pkg.sv
// Shared types for the CPU-side send/ack receive hub.
package cpu_hs_pkg;

   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_ACK  = 1'b1
   } rx_state_e;

   typedef logic src_t;

   localparam src_t SRC_P1 = 1'b0;
   localparam src_t SRC_P2 = 1'b1;

endpackage

// File: rtl/hs_rx_channel.sv
// One receive channel: send synchroniser, 4-phase FSM and registered ack.
module hs_rx_channel
   import cpu_hs_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic send,
   input  logic grant,
   output logic req_c,
   output logic ack
);

   logic [SYNC_STAGES-1:0] sync_q;
   rx_state_e              state;
   logic                   send_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], send};
      end
   end

   assign send_s = sync_q[SYNC_STAGES-1];

   // Only an idle channel may request, so each send pulse yields one word.
   assign req_c = (state == RX_IDLE) && send_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RX_IDLE;
         ack   <= 1'b0;
      end else begin
         case (state)
            RX_IDLE: begin
               if (grant) begin
                  state <= RX_ACK;
                  ack   <= 1'b1;
               end
            end
            RX_ACK: begin
               if (!send_s) begin
                  state <= RX_IDLE;
                  ack   <= 1'b0;
               end
            end
            default: begin
               state <= RX_IDLE;
               ack   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cpu_hs_rx_hub.sv
// Two-peripheral receive hub: round-robin capture into a FIFO drained by a valid/ready stream.
module cpu_hs_rx_hub
   import cpu_hs_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clkCPU,
   input  logic                         rstCPU,
   input  logic                         inSend1,
   input  logic [DATA_W-1:0]            inData1,
   output logic                         outAck1,
   input  logic                         inSend2,
   input  logic [DATA_W-1:0]            inData2,
   output logic                         outAck2,
   output logic                         outValid,
   output logic [DATA_W-1:0]            outData,
   output logic                         outSrc,
   input  logic                         inReady,
   output logic [$clog2(FIFO_DEPTH):0]  outLevel
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic              req1_c, req2_c;
   logic              grant1_c, grant2_c;
   logic              pop_c, push_c, room_c, tie_c, bypass_c;
   src_t              push_src_c;
   logic [DATA_W-1:0] push_data_c;
   src_t              rr_ptr;

   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   src_t              mem_src  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_c;
   logic [LVL_W-1:0]  level_c;

   hs_rx_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch1 (
      .clk   (clkCPU),
      .rst_n (rstCPU),
      .send  (inSend1),
      .grant (grant1_c),
      .req_c (req1_c),
      .ack   (outAck1)
   );

   hs_rx_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch2 (
      .clk   (clkCPU),
      .rst_n (rstCPU),
      .send  (inSend2),
      .grant (grant2_c),
      .req_c (req2_c),
      .ack   (outAck2)
   );

   // Arbitration: a pop this edge frees a slot, so a full FIFO can still accept.
   always_comb begin
      pop_c    = outValid && inReady;
      room_c   = (outLevel != LVL_W'(FIFO_DEPTH)) || pop_c;
      grant1_c = 1'b0;
      grant2_c = 1'b0;
      if (room_c) begin
         if (req1_c && req2_c) begin
            grant1_c = (rr_ptr == SRC_P1);
            grant2_c = (rr_ptr == SRC_P2);
         end else begin
            grant1_c = req1_c;
            grant2_c = req2_c;
         end
      end
      tie_c       = room_c && req1_c && req2_c;
      push_c      = grant1_c || grant2_c;
      push_src_c  = grant2_c ? SRC_P2 : SRC_P1;
      push_data_c = grant2_c ? inData2 : inData1;
   end

   // Pointer moves only on a contested grant.
   always_ff @(posedge clkCPU or negedge rstCPU) begin
      if (!rstCPU) begin
         rr_ptr <= SRC_P1;
      end else if (tie_c) begin
         rr_ptr <= ~rr_ptr;
      end
   end

   always_ff @(posedge clkCPU) begin
      if (push_c) begin
         mem_data[wr_ptr] <= push_data_c;
         mem_src[wr_ptr]  <= push_src_c;
      end
   end

   // A push into an empty (or emptying) FIFO bypasses storage straight to the head registers.
   always_comb begin
      rd_ptr_c = rd_ptr + PTR_W'(pop_c);
      level_c  = outLevel + LVL_W'(push_c) - LVL_W'(pop_c);
      bypass_c = push_c && (outLevel == LVL_W'(pop_c));
   end

   always_ff @(posedge clkCPU or negedge rstCPU) begin
      if (!rstCPU) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         outLevel <= '0;
         outValid <= 1'b0;
         outData  <= '0;
         outSrc   <= SRC_P1;
      end else begin
         wr_ptr   <= wr_ptr + PTR_W'(push_c);
         rd_ptr   <= rd_ptr_c;
         outLevel <= level_c;
         outValid <= (level_c != '0);
         if (bypass_c) begin
            outData <= push_data_c;
            outSrc  <= push_src_c;
         end else if (level_c != '0) begin
            outData <= mem_data[rd_ptr_c];
            outSrc  <= mem_src[rd_ptr_c];
         end
      end
   end

endmodule

// File: tb/tb_cpu_hs_rx_hub.sv
// Directed bench for cpu_hs_rx_hub with a scoreboard queue checked by a separate monitor.
module tb_cpu_hs_rx_hub;

   logic        clkCPU = 1'b0;
   logic        rstCPU;
   logic        inSend1, inSend2, inReady;
   logic [15:0] inData1, inData2;
   logic        outAck1, outAck2, outValid, outSrc;
   logic [15:0] outData;
   logic [2:0]  outLevel;

   int checks   = 0;
   int failures = 0;
   logic [16:0] exp_q [$];

   cpu_hs_rx_hub dut (
      .clkCPU   (clkCPU),
      .rstCPU   (rstCPU),
      .inSend1  (inSend1),
      .inData1  (inData1),
      .outAck1  (outAck1),
      .inSend2  (inSend2),
      .inData2  (inData2),
      .outAck2  (outAck2),
      .outValid (outValid),
      .outData  (outData),
      .outSrc   (outSrc),
      .inReady  (inReady),
      .outLevel (outLevel)
   );

   always #5 clkCPU = ~clkCPU;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clkCPU);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic wait_ack(input int ch, input logic v, input string nm);
      int n = 0;
      while (((ch == 1) ? outAck1 : outAck2) !== v && n < 20) begin
         tick();
         n++;
      end
      chk(nm, (ch == 1) ? outAck1 : outAck2, v);
   endtask

   task automatic set_send(input int ch, input logic s, input logic [15:0] d);
      if (ch == 1) begin inSend1 = s; inData1 = d; end
      else         begin inSend2 = s; inData2 = d; end
   endtask

   task automatic handshake(input int ch, input logic [15:0] d);
      exp_q.push_back({(ch == 2) ? 1'b1 : 1'b0, d});
      set_send(ch, 1'b1, d);
      wait_ack(ch, 1'b1, "hs_ack_rise");
      set_send(ch, 1'b0, d);
      wait_ack(ch, 1'b0, "hs_ack_fall");
   endtask

   task automatic drain();
      int n = 0;
      inReady = 1'b1;
      while (outLevel != 3'd0 && n < 20) begin
         tick();
         n++;
      end
      inReady = 1'b0;
      chk("drain_level", outLevel, 3'd0);
      chk("drain_valid", outValid, 1'b0);
   endtask

   // Monitor: every accepted head word must match the oldest expected word.
   initial begin
      forever begin
         @(negedge clkCPU);
         if (rstCPU && outValid && inReady) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL mon_unexpected actual=%0h/%0b required=none", outData, outSrc);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               if ({outSrc, outData} !== e) begin
                  failures++;
                  $display("FAIL mon_word actual=%0b/%0h required=%0b/%0h",
                           outSrc, outData, e[16], e[15:0]);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstCPU = 1'b0; inSend1 = 0; inSend2 = 0; inReady = 0; inData1 = '0; inData2 = '0;
      tick(2);
      chk("rst_ack1", outAck1, 1'b0);
      chk("rst_ack2", outAck2, 1'b0);
      chk("rst_valid", outValid, 1'b0);
      chk("rst_data", outData, 16'h0);
      chk("rst_src", outSrc, 1'b0);
      chk("rst_level", outLevel, 3'd0);
      rstCPU = 1'b1;
      tick();

      // Single word and its latency.
      exp_q.push_back({1'b0, 16'h00A5});
      set_send(1, 1'b1, 16'h00A5);
      tick(2);
      chk("sw_ack_early", outAck1, 1'b0);
      chk("sw_valid_early", outValid, 1'b0);
      tick();
      chk("sw_ack", outAck1, 1'b1);
      chk("sw_valid", outValid, 1'b1);
      chk("sw_data", outData, 16'h00A5);
      chk("sw_src", outSrc, 1'b0);
      chk("sw_level", outLevel, 3'd1);
      set_send(1, 1'b0, 16'h00A5);
      tick(2);
      chk("sw_ack_hold", outAck1, 1'b1);
      tick();
      chk("sw_ack_drop", outAck1, 1'b0);
      inReady = 1'b1;
      tick();
      inReady = 1'b0;
      chk("sw_pop_valid", outValid, 1'b0);
      chk("sw_pop_level", outLevel, 3'd0);

      // Tie: pointer starts at peripheral 1, next tie goes to peripheral 2.
      exp_q.push_back({1'b0, 16'h1111});
      exp_q.push_back({1'b1, 16'h2222});
      set_send(1, 1'b1, 16'h1111);
      set_send(2, 1'b1, 16'h2222);
      tick(3);
      chk("tie1_ack1", outAck1, 1'b1);
      chk("tie1_ack2", outAck2, 1'b0);
      tick();
      chk("tie1_ack2_late", outAck2, 1'b1);
      chk("tie1_level", outLevel, 3'd2);
      set_send(1, 1'b0, 16'h1111);
      set_send(2, 1'b0, 16'h2222);
      tick(4);
      exp_q.push_back({1'b1, 16'h4444});
      exp_q.push_back({1'b0, 16'h3333});
      set_send(1, 1'b1, 16'h3333);
      set_send(2, 1'b1, 16'h4444);
      tick(3);
      chk("tie2_ack2", outAck2, 1'b1);
      chk("tie2_ack1", outAck1, 1'b0);
      tick();
      chk("tie2_ack1_late", outAck1, 1'b1);
      chk("tie2_level", outLevel, 3'd4);
      set_send(1, 1'b0, 16'h3333);
      set_send(2, 1'b0, 16'h4444);
      tick(4);
      drain();

      // Fill, backpressure, then pop and push on the same edge while full.
      for (int i = 0; i < 4; i++) handshake(1, 16'hA0A0 + 16'(i));
      chk("fill_level", outLevel, 3'd4);
      exp_q.push_back({1'b1, 16'hB5B5});
      set_send(2, 1'b1, 16'hB5B5);
      tick(6);
      chk("full_noack", outAck2, 1'b0);
      chk("full_level", outLevel, 3'd4);
      inReady = 1'b1;
      tick();
      inReady = 1'b0;
      chk("full_popush_ack", outAck2, 1'b1);
      chk("full_popush_level", outLevel, 3'd4);
      chk("full_head", outData, 16'hA0A1);
      set_send(2, 1'b0, 16'hB5B5);
      wait_ack(2, 1'b0, "full_ack_fall");
      drain();

      // Long send: one word only, ack held throughout.
      exp_q.push_back({1'b0, 16'hC0DE});
      set_send(1, 1'b1, 16'hC0DE);
      tick(3);
      chk("long_ack", outAck1, 1'b1);
      tick(10);
      chk("long_ack_held", outAck1, 1'b1);
      chk("long_level", outLevel, 3'd1);
      set_send(1, 1'b0, 16'hC0DE);
      wait_ack(1, 1'b0, "long_ack_fall");
      chk("long_level_end", outLevel, 3'd1);
      drain();

      // Async reset in the middle of a handshake.
      handshake(1, 16'hD1D1);
      set_send(1, 1'b1, 16'hD2D2);
      wait_ack(1, 1'b1, "rst_mid_ack");
      chk("rst_mid_level", outLevel, 3'd2);
      #2;
      rstCPU = 1'b0;
      #1;
      chk("rst_mid_ack0", outAck1, 1'b0);
      chk("rst_mid_valid0", outValid, 1'b0);
      chk("rst_mid_level0", outLevel, 3'd0);
      exp_q.delete();
      tick();
      rstCPU = 1'b1;
      exp_q.push_back({1'b0, 16'hD2D2});
      tick(2);
      chk("rst_rel_ack_early", outAck1, 1'b0);
      tick();
      chk("rst_rel_ack", outAck1, 1'b1);
      chk("rst_rel_level", outLevel, 3'd1);
      chk("rst_rel_data", outData, 16'hD2D2);
      set_send(1, 1'b0, 16'hD2D2);
      wait_ack(1, 1'b0, "rst_rel_ack_fall");
      drain();

      tick(2);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
